// File: rtl/udp_tx_scheduler_if.sv
// Bundle of the scheduler's requester-side and downstream byte-stream signals.
// master: the scheduler itself. slave: the surrounding sources/sink.
interface udp_tx_scheduler_if #(
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ*16-1:0] port_s_in;
  logic [N_REQ*16-1:0] port_d_in;
  logic [N_REQ*16-1:0] len_in;
  logic [N_REQ*8-1:0]  payload_data;
  logic [N_REQ-1:0]    payload_valid;
  logic [N_REQ-1:0]    payload_ready;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    done;
  logic [N_REQ-1:0]    err;
  logic [7:0]          m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;
  logic                busy;

  modport master (
    input  req, port_s_in, port_d_in, len_in, payload_data, payload_valid, m_ready,
    output payload_ready, grant, done, err, m_data, m_valid, m_last, busy
  );

  modport slave (
    output req, port_s_in, port_d_in, len_in, payload_data, payload_valid, m_ready,
    input  payload_ready, grant, done, err, m_data, m_valid, m_last, busy
  );

endinterface

// File: rtl/udp_tx_scheduler.sv
// Round-robin UDP transmit scheduler: grants one requester per datagram,
// emits the 8-byte UDP header (checksum 0) and then passes the granted
// requester's payload bytes straight through to the downstream stream.
module udp_tx_scheduler #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned MAX_PAYLOAD = 1472
) (
  input  logic               aclk,
  input  logic               areset,
  udp_tx_scheduler_if.master bus
);

  localparam int unsigned IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     sel_q, sel_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic              busy_q, busy_d;
  logic [15:0]       src_q, src_d;
  logic [15:0]       dst_q, dst_d;
  logic [15:0]       len_q, len_d;

  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic [IW-1:0]     cand;
  logic [15:0]       pick_src;
  logic [15:0]       pick_dst;
  logic [15:0]       pick_len;

  logic [15:0]       hdr_len;
  logic [7:0]        m_data_c;
  logic              m_valid_c;
  logic              m_last_c;
  logic [N_REQ-1:0]  pready_c;
  logic              xfer;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return IW'((32'(i) + 32'd1) % N_REQ);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First requesting index at or above the rr pointer, wrapping modulo N_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IW'((32'(rr_q) + k) % N_REQ);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign pick_src = bus.port_s_in[16*pick_idx +: 16];
  assign pick_dst = bus.port_d_in[16*pick_idx +: 16];
  assign pick_len = bus.len_in[16*pick_idx +: 16];
  assign hdr_len  = len_q + 16'd8;

  // Downstream byte/valid/last and per-requester ready for the current state.
  always_comb begin
    m_data_c  = '0;
    m_valid_c = 1'b0;
    m_last_c  = 1'b0;
    pready_c  = '0;
    case (state_q)
      S_HEADER: begin
        // Header outputs come only from registers so they never follow m_ready.
        m_valid_c = 1'b1;
        case (cnt_q[2:0])
          3'd0:    m_data_c = src_q[15:8];
          3'd1:    m_data_c = src_q[7:0];
          3'd2:    m_data_c = dst_q[15:8];
          3'd3:    m_data_c = dst_q[7:0];
          3'd4:    m_data_c = hdr_len[15:8];
          3'd5:    m_data_c = hdr_len[7:0];
          default: m_data_c = 8'h00;
        endcase
        m_last_c = (cnt_q[2:0] == 3'd7) && (len_q == 16'd0);
      end
      S_PAYLOAD: begin
        m_data_c        = bus.payload_data[8*sel_q +: 8];
        m_valid_c       = bus.payload_valid[sel_q];
        pready_c[sel_q] = bus.m_ready;
        m_last_c        = (cnt_q == (len_q - 16'd1)) && m_valid_c;
      end
      default: ;
    endcase
  end

  assign xfer = m_valid_c && bus.m_ready;

  // Arbitration, header/payload sequencing and datagram completion.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = '0;
    busy_d  = busy_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          src_d = pick_src;
          dst_d = pick_dst;
          len_d = pick_len;
          sel_d = pick_idx;
          if (pick_len > MAX_LEN) begin
            err_d = onehot(pick_idx);
            rr_d  = wrap_inc(pick_idx);
          end else begin
            grant_d = onehot(pick_idx);
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        if (xfer) begin
          if (cnt_q[2:0] == 3'd7) begin
            cnt_d = '0;
            if (len_q == 16'd0) begin
              state_d = S_DONE;
              done_d  = grant_q;
              busy_d  = 1'b0;
            end else begin
              state_d = S_PAYLOAD;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          cnt_d = cnt_q + 16'd1;
          if (m_last_c) begin
            state_d = S_DONE;
            done_d  = grant_q;
            busy_d  = 1'b0;
          end
        end
      end
      S_DONE: begin
        // done pulses while in this state; grant is released on the way out.
        grant_d = '0;
        busy_d  = 1'b0;
        rr_d    = wrap_inc(sel_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; asynchronous reset abandons any datagram in flight.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.busy          = busy_q;
  assign bus.m_data        = m_data_c;
  assign bus.m_valid       = m_valid_c;
  assign bus.m_last        = m_last_c;
  assign bus.payload_ready = pready_c;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Scoreboard bench for udp_tx_scheduler: directed datagrams push expected
// bytes/events into queues, a monitor pops and compares on every transfer.
module tb_udp_tx_scheduler;

  localparam int unsigned N = 4;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  udp_tx_scheduler_if #(.N_REQ(N)) bif ();

  udp_tx_scheduler #(.N_REQ(N), .MAX_PAYLOAD(1472)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bif)
  );

  typedef struct {
    logic [7:0]   d;
    logic         last;
    logic [N-1:0] g;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ev_q[$];     // {done, err}
  int          total = 0;
  int          bad   = 0;

  logic [7:0]  pay [N][32];
  int          pay_n [N];
  int          rd [N];
  logic        bub [N][8];
  int          bub_n [N];
  int          brd [N];
  int          pending [N];
  logic        toggle;

  logic        hold;
  logic [7:0]  pdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, req_v, $time);
    end
  endtask

  task automatic push_b(input int g, input logic [7:0] d, input logic last);
    exp_t e;
    logic [N-1:0] one;
    one    = 1;
    e.d    = d;
    e.last = last;
    e.g    = one << g;
    exp_q.push_back(e);
  endtask

  task automatic push_hdr(input int g, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] len);
    logic [15:0] l8;
    l8 = len + 16'd8;
    push_b(g, s[15:8], 1'b0);
    push_b(g, s[7:0], 1'b0);
    push_b(g, d[15:8], 1'b0);
    push_b(g, d[7:0], 1'b0);
    push_b(g, l8[15:8], 1'b0);
    push_b(g, l8[7:0], 1'b0);
    push_b(g, 8'h00, 1'b0);
    push_b(g, 8'h00, len == 16'd0);
  endtask

  task automatic load(input int i, input logic [15:0] s, input logic [15:0] d,
                      input logic [15:0] len);
    bif.port_s_in[16*i +: 16] = s;
    bif.port_d_in[16*i +: 16] = d;
    bif.len_in[16*i +: 16]    = len;
  endtask

  task automatic add_pay(input int i, input logic [7:0] b);
    pay[i][pay_n[i]] = b;
    pay_n[i]++;
  endtask

  // Wait for n done/err pulses; the requester drops req as soon as it sees one.
  task automatic run_until(input int n, input int budget);
    int got;
    int cyc;
    logic [N-1:0] dn;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge aclk);
      dn = bif.done | bif.err;
      for (int i = 0; i < N; i++) begin
        if (dn[i]) begin
          got++;
          pending[i]--;
          if (pending[i] <= 0) bif.req[i] = 1'b0;
        end
      end
      cyc++;
    end
    chk("completions", got, n);
  endtask

  // Requester payload sources and downstream m_ready pattern.
  initial begin
    logic [N-1:0] xf;
    logic [N-1:0] xr;
    bif.m_ready       = 1'b1;
    bif.payload_valid = '0;
    bif.payload_data  = '0;
    for (int i = 0; i < N; i++) begin
      rd[i]  = 0;
      brd[i] = 0;
    end
    forever begin
      @(negedge aclk);
      xf = bif.payload_valid & bif.payload_ready;
      xr = bif.payload_ready;
      @(posedge aclk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (brd[i] < bub_n[i] && !bub[i][brd[i]] && xr[i]) begin
          brd[i]++;
        end else if (xf[i]) begin
          rd[i]++;
          if (brd[i] < bub_n[i]) brd[i]++;
        end
        bif.payload_valid[i] = (rd[i] < pay_n[i]) &&
                               ((brd[i] >= bub_n[i]) || bub[i][brd[i]]);
        bif.payload_data[8*i +: 8] = (rd[i] < pay_n[i]) ? pay[i][rd[i]] : 8'h00;
      end
      bif.m_ready = toggle ? ~bif.m_ready : 1'b1;
    end
  end

  // Monitor: scoreboard pops, backpressure stability, ready/grant and pulse checks.
  always @(negedge aclk) begin
    exp_t e;
    logic [7:0] ev;
    if (areset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 32'(bif.m_valid), 32'd1);
        chk("hold_data", 32'(bif.m_data), 32'(pdata));
      end
      hold  = bif.m_valid && !bif.m_ready;
      pdata = bif.m_data;
      if (bif.m_valid && bif.m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(bif.m_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("byte_data", 32'(bif.m_data), 32'(e.d));
          chk("byte_last", 32'(bif.m_last), 32'(e.last));
          chk("byte_grant", 32'(bif.grant), 32'(e.g));
        end
      end
      if (bif.busy) chk("pready_granted_only", 32'(bif.payload_ready & ~bif.grant), 32'd0);
      if ((bif.done | bif.err) != '0) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_pulse", 32'({bif.done, bif.err}), 32'hFFFF_FFFF);
        end else begin
          ev = ev_q.pop_front();
          chk("done_err_pulse", 32'({bif.done, bif.err}), 32'(ev));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] t1 [11];
    int w;
    t1 = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0B, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    areset           = 1'b1;
    toggle           = 1'b0;
    hold             = 1'b0;
    pdata            = '0;
    bif.req          = '0;
    bif.port_s_in    = '0;
    bif.port_d_in    = '0;
    bif.len_in       = '0;
    for (int i = 0; i < N; i++) begin
      pay_n[i]   = 0;
      bub_n[i]   = 0;
      pending[i] = 0;
    end
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_grant", 32'(bif.grant), 32'd0);
    chk("rst_m_valid", 32'(bif.m_valid), 32'd0);
    chk("rst_m_last", 32'(bif.m_last), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_done_err", 32'({bif.done, bif.err}), 32'd0);
    chk("rst_pready", 32'(bif.payload_ready), 32'd0);
    chk("rst_m_data", 32'(bif.m_data), 32'd0);

    // Round robin: all four request together, requester 0 has two datagrams.
    for (int i = 0; i < N; i++) begin
      load(i, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'd1);
      add_pay(i, 8'h10 + 8'(i));
      pending[i] = 1;
    end
    pending[0] = 2;
    add_pay(0, 8'h50);
    for (int i = 0; i < N; i++) begin
      push_hdr(i, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'd1);
      push_b(i, 8'h10 + 8'(i), 1'b1);
    end
    push_hdr(0, 16'h1000, 16'h2000, 16'd1);
    push_b(0, 8'h50, 1'b1);
    ev_q.push_back(8'h10);
    ev_q.push_back(8'h20);
    ev_q.push_back(8'h40);
    ev_q.push_back(8'h80);
    ev_q.push_back(8'h10);
    @(posedge aclk);
    #1;
    bif.req = 4'b1111;
    run_until(5, 300);

    // Single request on requester 2, literal byte sequence, 1-cycle latency.
    load(2, 16'h1234, 16'h0050, 16'd3);
    add_pay(2, 8'hAA);
    add_pay(2, 8'hBB);
    add_pay(2, 8'hCC);
    pending[2] = 1;
    for (int k = 0; k < 11; k++) push_b(2, t1[k], k == 10);
    ev_q.push_back(8'h40);
    @(posedge aclk);
    #1;
    bif.req[2] = 1'b1;
    @(negedge aclk);
    chk("latency_before", 32'(bif.m_valid), 32'd0);
    @(negedge aclk);
    chk("latency_valid", 32'(bif.m_valid), 32'd1);
    chk("latency_grant", 32'(bif.grant), 32'b0100);
    run_until(1, 100);

    // Backpressure: m_ready alternates through header and payload.
    load(1, 16'hABCD, 16'h00FF, 16'd2);
    add_pay(1, 8'h5A);
    add_pay(1, 8'hA5);
    pending[1] = 1;
    push_hdr(1, 16'hABCD, 16'h00FF, 16'd2);
    push_b(1, 8'h5A, 1'b0);
    push_b(1, 8'hA5, 1'b1);
    ev_q.push_back(8'h20);
    toggle = 1'b1;
    @(posedge aclk);
    #1;
    bif.req[1] = 1'b1;
    run_until(1, 200);
    toggle = 1'b0;

    // Zero-length datagram: header only, last on byte 7.
    load(3, 16'h0007, 16'h0009, 16'd0);
    pending[3] = 1;
    push_hdr(3, 16'h0007, 16'h0009, 16'd0);
    ev_q.push_back(8'h80);
    @(posedge aclk);
    #1;
    bif.req[3] = 1'b1;
    run_until(1, 100);

    // Oversized request is rejected without output.
    load(0, 16'h0101, 16'h0202, 16'd1500);
    pending[0] = 1;
    ev_q.push_back(8'h01);
    @(posedge aclk);
    #1;
    bif.req[0] = 1'b1;
    run_until(1, 50);
    chk("reject_no_valid", 32'(bif.m_valid), 32'd0);
    chk("reject_no_grant", 32'(bif.grant), 32'd0);

    // rr pointer moved past 0: with 0 and 1 requesting, 1 goes first.
    load(0, 16'h0A0A, 16'h0B0B, 16'd1);
    add_pay(0, 8'h77);
    load(1, 16'h0C0C, 16'h0D0D, 16'd1);
    add_pay(1, 8'h88);
    pending[0] = 1;
    pending[1] = 1;
    push_hdr(1, 16'h0C0C, 16'h0D0D, 16'd1);
    push_b(1, 8'h88, 1'b1);
    push_hdr(0, 16'h0A0A, 16'h0B0B, 16'd1);
    push_b(0, 8'h77, 1'b1);
    ev_q.push_back(8'h20);
    ev_q.push_back(8'h10);
    @(posedge aclk);
    #1;
    bif.req = 4'b0011;
    run_until(2, 200);

    // Payload bubbles on requester 2: valid pattern 1,0,0,1,1.
    load(2, 16'h3333, 16'h4444, 16'd3);
    add_pay(2, 8'h11);
    add_pay(2, 8'h22);
    add_pay(2, 8'h33);
    bub[2][0] = 1'b1;
    bub[2][1] = 1'b0;
    bub[2][2] = 1'b0;
    bub[2][3] = 1'b1;
    bub[2][4] = 1'b1;
    bub_n[2]  = 5;
    pending[2] = 1;
    push_hdr(2, 16'h3333, 16'h4444, 16'd3);
    push_b(2, 8'h11, 1'b0);
    push_b(2, 8'h22, 1'b0);
    push_b(2, 8'h33, 1'b1);
    ev_q.push_back(8'h40);
    @(posedge aclk);
    #1;
    bif.req[2] = 1'b1;
    run_until(1, 100);

    // Reset after 2 of 5 payload bytes of requester 1.
    load(1, 16'h5555, 16'h6666, 16'd5);
    for (int k = 1; k <= 5; k++) add_pay(1, 8'(k));
    pending[1] = 1;
    push_hdr(1, 16'h5555, 16'h6666, 16'd5);
    push_b(1, 8'h01, 1'b0);
    push_b(1, 8'h02, 1'b0);
    @(posedge aclk);
    #1;
    bif.req[1] = 1'b1;
    w = 0;
    do begin
      @(negedge aclk);
      #1;
      w++;
    end while (exp_q.size() != 0 && w < 100);
    chk("pre_reset_drain", 32'(exp_q.size()), 32'd0);
    @(posedge aclk);
    #2;
    areset = 1'b1;
    #1;
    chk("async_grant", 32'(bif.grant), 32'd0);
    chk("async_m_valid", 32'(bif.m_valid), 32'd0);
    chk("async_busy", 32'(bif.busy), 32'd0);
    chk("async_m_data", 32'(bif.m_data), 32'd0);
    bif.req    = '0;
    pending[1] = 0;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // After reset rr is 0: requesters 0 and 3 together, 0 goes first.
    load(0, 16'h0E0E, 16'h0F0F, 16'd1);
    add_pay(0, 8'h99);
    load(3, 16'h0303, 16'h0404, 16'd1);
    add_pay(3, 8'hAB);
    pending[0] = 1;
    pending[3] = 1;
    push_hdr(0, 16'h0E0E, 16'h0F0F, 16'd1);
    push_b(0, 8'h99, 1'b1);
    push_hdr(3, 16'h0303, 16'h0404, 16'd1);
    push_b(3, 8'hAB, 1'b1);
    ev_q.push_back(8'h10);
    ev_q.push_back(8'h80);
    @(posedge aclk);
    #1;
    bif.req = 4'b1001;
    run_until(2, 200);

    repeat (4) @(negedge aclk);
    chk("exp_bytes_left", 32'(exp_q.size()), 32'd0);
    chk("exp_events_left", 32'(ev_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
